bpsk_bit_serializer: RTL and testbench
======================================

Name: bpsk_bit_serializer

Overview:
- Downstream consumer of the en_generator bit-rate strobe.
- Accepts parallel data words over a valid/ready handshake and frames them as a preamble, FRAME_WORDS data words and a gap.
- Emits one bit per en strobe to the BPSK modulator.
- Flags underrun when the source cannot keep pace with the bit rate.

Parameters:
- DATA_WIDTH, 8: bits per input word.
- FRAME_WORDS, 4: data words per frame, 1..255.
- PRE_LEN, 13: preamble length in bits, 1..32.
- PREAMBLE, 32'h00001F35: preamble pattern; bits [PRE_LEN-1:0] are used and sent MSB first (Barker-13 by default).
- GAP_BITS, 2: zero bits appended after each frame, 0..255.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bit strobe from en_generator; one bit is emitted per cycle with en=1.
- s_data  in  DATA_WIDTH  input word.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  holding register empty; word accepted when s_valid&&s_ready.
- bit_out  out  1  serial bit to the modulator.
- bit_valid  out  1  one-cycle pulse; bit_out holds a newly emitted bit.
- frame_start  out  1  one-cycle pulse coincident with bit_valid of the first preamble bit.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky; cleared only by rst.

Behaviour:
- Reset values:
  - state=IDLE, holding register empty (s_ready=1 from the first cycle after reset).
  - bit_out=0, bit_valid=0, frame_start=0, busy=0, underrun=0.
  - Bit and word counters = 0.
  - rst mid-frame aborts immediately and discards the held and shifting words.
- Datapath:
  - One holding register plus one shift register (double buffer).
  - s_ready = !hold_full, registered view with no bypass. If the holding register is consumed and a word is offered in the same cycle, the offer is not accepted that cycle.
- Emission rule:
  - All state/counter advances and bit_out updates happen only on clock edges where en=1.
  - bit_valid=1 in the cycle after such an edge when the emitted bit is a preamble, data or gap bit. Latency is en to bit_valid = 1 cycle.
  - In IDLE, en strobes produce no bit_valid and bit_out=0.
- FSM:
  - IDLE: on en with hold_full, go to PREAMBLE and emit PREAMBLE[PRE_LEN-1]; frame_start pulses. Otherwise stay.
  - PREAMBLE: emit PREAMBLE[PRE_LEN-1-k] for k=1..PRE_LEN-1. On the en after the last preamble bit, enter DATA.
  - DATA: at the first bit of each word, move holding to shift, set hold_full=0 and emit the MSB. The remaining DATA_WIDTH-1 bits are MSB first. After word FRAME_WORDS bit 0, enter GAP (or IDLE if GAP_BITS=0).
  - GAP: emit 0 for GAP_BITS strobes, then enter IDLE. A held word may start the next frame on the next en after entering IDLE.
- Underrun: in DATA, if a word is needed but hold_full=0 at that en:
  - emit 0 with bit_valid=1;
  - set underrun=1;
  - abort the frame and enter GAP; the word counter is reset.
- Counters:
  - Bit counter is $clog2(max(DATA_WIDTH,PRE_LEN,GAP_BITS))+1 bits wide; word counter is 8 bits.
  - All comparisons are exact-equality terminal counts; there is no wrap-around inside a frame.
- en held high every cycle is legal: one bit per clock.
- en=0 freezes all serialization state; the handshake still runs.

Decomposition:
- Package bpsk_pkg:
  - state enum (IDLE, PREAMBLE, DATA, GAP);
  - BARKER13 = 13'b1111100110101;
  - default DATA_WIDTH.
- No sub-module; a single FSM plus datapath. Testbench reuses en_generator for strobe generation.

Test Plan:
- Basic frame:
  - Stimulus: INTERVAL=3 strobe; push 8'hA5, 8'h3C, 8'hFF, 8'h00 before the first en.
  - Expected response: bit_valid stream = 1111100110101, then 10100101 00111100 11111111 00000000, then 00.
  - frame_start pulses once; busy is high for 47 strobes.
- Handshake backpressure:
  - Stimulus: hold s_valid=1 with incrementing data.
  - Expected response: s_ready drops after each accept and rises on the en that loads the shift register. No word is lost or duplicated across 3 frames.
- Underrun:
  - Stimulus: supply only 2 words of a 4-word frame.
  - Expected response: after word 2, one 0 bit is emitted, then 2 gap zeros; underrun=1 stays set; IDLE is entered.
- en continuous:
  - Stimulus: en=1 every cycle, one frame.
  - Expected response: 47 consecutive bit_valid cycles with the same bit sequence as the basic-frame scenario.
- Mid-frame reset:
  - Stimulus: assert rst at data bit 5 of word 1.
  - Expected response: next cycle bit_valid=0, busy=0, s_ready=1, underrun=0; no further bits until a new word arrives.
- Parameter corner:
  - Stimulus: FRAME_WORDS=1, GAP_BITS=0, PRE_LEN=1, PREAMBLE=1.
  - Expected response: per word, bit stream 1 followed by 8 data bits; back-to-back frames with no idle strobe when data is ready.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK bit serializer.
// Holds the FSM state encoding, the default Barker-13 preamble and the counter sizing helper.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int          DEFAULT_DATA_WIDTH = 8;
  localparam logic [12:0] BARKER13           = 13'b1111100110101;

  // One counter serves every phase, so it must reach the longest phase length inclusively.
  function automatic int bit_cnt_width(input int dw, input int pl, input int gb);
    int m;
    m = dw;
    if (pl > m) begin
      m = pl;
    end
    if (gb > m) begin
      m = gb;
    end
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/bpsk_bit_serializer.sv
// Frames parallel words as preamble + FRAME_WORDS data words + zero gap and shifts them out
// one bit per en strobe, with a one-word holding register in front of the shift register.
module bpsk_bit_serializer
  import bpsk_pkg::*;
#(
  parameter int          DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int          FRAME_WORDS = 4,
  parameter int          PRE_LEN     = 13,
  parameter logic [31:0] PREAMBLE    = 32'h00001F35,
  parameter int          GAP_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  frame_start,
  output logic                  busy,
  output logic                  underrun
);

  localparam int          CW          = bit_cnt_width(DATA_WIDTH, PRE_LEN, GAP_BITS);
  localparam logic [31:0] PRE_ALIGNED = PREAMBLE << (32 - PRE_LEN);

  state_t                state_r;
  logic [DATA_WIDTH-1:0] hold_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  hold_full_r;
  logic [31:0]           pre_sr_r;
  logic [CW-1:0]         bit_cnt_r;
  logic [7:0]            word_cnt_r;
  logic                  bit_out_r;
  logic                  bit_valid_r;
  logic                  frame_start_r;
  logic                  underrun_r;

  logic pre_done_s;
  logic word_done_s;
  logic last_word_s;
  logic gap_done_s;
  logic need_word_s;
  logic frame_end_s;
  logic start_frame_s;
  logic consume_s;
  logic accept_s;

  // Phase terminal counts and the per-strobe decisions shared by the FSM.
  always_comb begin
    pre_done_s  = (bit_cnt_r == CW'(PRE_LEN - 1));
    word_done_s = (bit_cnt_r == CW'(DATA_WIDTH - 1));
    last_word_s = (word_cnt_r == 8'(FRAME_WORDS));
    gap_done_s  = (bit_cnt_r == CW'(GAP_BITS));
    need_word_s = 1'b0;
    frame_end_s = 1'b0;
    if (en) begin
      case (state_r)
        ST_PREAMBLE: begin
          need_word_s = pre_done_s;
        end
        ST_DATA: begin
          need_word_s = word_done_s && !last_word_s;
          frame_end_s = word_done_s && last_word_s && (GAP_BITS == 0);
        end
        ST_GAP: begin
          frame_end_s = gap_done_s;
        end
        default: begin
          need_word_s = 1'b0;
          frame_end_s = 1'b0;
        end
      endcase
    end else begin
      need_word_s = 1'b0;
      frame_end_s = 1'b0;
    end
    // A frame-ending strobe behaves like an IDLE strobe, so ready data chains with no idle bit.
    start_frame_s = hold_full_r && en && ((state_r == ST_IDLE) || frame_end_s);
    consume_s     = need_word_s && hold_full_r;
    accept_s      = s_valid && !hold_full_r;
  end

  // Handshake, framing FSM and serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      hold_r        <= {DATA_WIDTH{1'b0}};
      shift_r       <= {DATA_WIDTH{1'b0}};
      hold_full_r   <= 1'b0;
      pre_sr_r      <= 32'd0;
      bit_cnt_r     <= {CW{1'b0}};
      word_cnt_r    <= 8'd0;
      bit_out_r     <= 1'b0;
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;

      if (accept_s) begin
        hold_r      <= s_data;
        hold_full_r <= 1'b1;
      end else if (consume_s) begin
        hold_full_r <= 1'b0;
      end

      if (start_frame_s) begin
        state_r       <= ST_PREAMBLE;
        bit_out_r     <= PRE_ALIGNED[31];
        pre_sr_r      <= PRE_ALIGNED << 1;
        bit_cnt_r     <= {CW{1'b0}};
        word_cnt_r    <= 8'd0;
        bit_valid_r   <= 1'b1;
        frame_start_r <= 1'b1;
      end else if (need_word_s) begin
        bit_valid_r <= 1'b1;
        bit_cnt_r   <= {CW{1'b0}};
        if (hold_full_r) begin
          state_r    <= ST_DATA;
          bit_out_r  <= hold_r[DATA_WIDTH-1];
          shift_r    <= hold_r << 1;
          word_cnt_r <= word_cnt_r + 8'd1;
        end else begin
          // Source fell behind: mark the hole with a zero and close the frame through the gap.
          state_r    <= ST_GAP;
          bit_out_r  <= 1'b0;
          underrun_r <= 1'b1;
          word_cnt_r <= 8'd0;
        end
      end else if (frame_end_s) begin
        state_r    <= ST_IDLE;
        bit_out_r  <= 1'b0;
        bit_cnt_r  <= {CW{1'b0}};
        word_cnt_r <= 8'd0;
      end else if (en) begin
        case (state_r)
          ST_IDLE: begin
            bit_out_r <= 1'b0;
          end
          ST_PREAMBLE: begin
            bit_out_r   <= pre_sr_r[31];
            pre_sr_r    <= pre_sr_r << 1;
            bit_cnt_r   <= bit_cnt_r + CW'(1);
            bit_valid_r <= 1'b1;
          end
          ST_DATA: begin
            bit_valid_r <= 1'b1;
            if (word_done_s) begin
              // Last word finished; the gap counter counts gap bits already sent.
              state_r   <= ST_GAP;
              bit_out_r <= 1'b0;
              bit_cnt_r <= CW'(1);
            end else begin
              bit_out_r <= shift_r[DATA_WIDTH-1];
              shift_r   <= shift_r << 1;
              bit_cnt_r <= bit_cnt_r + CW'(1);
            end
          end
          ST_GAP: begin
            bit_out_r   <= 1'b0;
            bit_cnt_r   <= bit_cnt_r + CW'(1);
            bit_valid_r <= 1'b1;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready     = ~hold_full_r;
  assign busy        = (state_r != ST_IDLE);
  assign bit_out     = bit_out_r;
  assign bit_valid   = bit_valid_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_bpsk_bit_serializer.sv
// Randomized self-checking bench: expected bit streams are built frame by frame from the
// word lists; a default instance and a minimal-frame instance run side by side.
module tb_bpsk_bit_serializer;
  import bpsk_pkg::*;

  typedef struct packed {
    logic b;
    logic fs;
    logic ws;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, bit_out, bit_valid, frame_start, busy, underrun;
  logic [7:0] c_data = 8'h00;
  logic       c_valid = 1'b0;
  logic       c_ready, c_bit, c_bv, c_fs, c_busy, c_under;

  bpsk_bit_serializer dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .frame_start(frame_start), .busy(busy),
    .underrun(underrun)
  );

  bpsk_bit_serializer #(.FRAME_WORDS(1), .PRE_LEN(1), .PREAMBLE(32'h1), .GAP_BITS(0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .s_data(c_data), .s_valid(c_valid), .s_ready(c_ready),
    .bit_out(c_bit), .bit_valid(c_bv), .frame_start(c_fs), .busy(c_busy), .underrun(c_under)
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t       exp0[$];
  exp_t       exp1[$];
  logic [7:0] src0[$];
  logic [7:0] src1[$];

  int   en_int = 3;
  bit   en_on = 1'b0;
  int   en_cnt = 0;
  int   cyc = 0;
  int   seen0 = 0, seen1 = 0;
  int   first0 = -1, last0 = -1, first1 = -1, last1 = -1;
  int   busy_str0 = 0;
  logic rdy0 = 1'b0, rdy1 = 1'b0, v0 = 1'b0, v1 = 1'b0, rst_smp = 1'b1;
  bit   pend0 = 1'b0, pend1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic void push_exp(input int which, input logic b, input logic fs, input logic ws);
    exp_t e;
    e.b  = b;
    e.fs = fs;
    e.ws = ws;
    if (which == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endfunction

  // Expected frame: preamble MSB first, each word MSB first, an underrun zero if words ran out, gap zeros.
  function automatic void add_frame(input int which, input logic [7:0] w[$], input int fw,
                                    input int pl, input logic [31:0] pre, input int gap);
    for (int k = 0; k < pl; k++) push_exp(which, pre[pl-1-k], k == 0, 1'b0);
    for (int i = 0; i < w.size(); i++)
      for (int j = 0; j < 8; j++) push_exp(which, w[i][7-j], 1'b0, j == 0);
    if (w.size() < fw) push_exp(which, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) push_exp(which, 1'b0, 1'b0, 1'b0);
  endfunction

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Strobe source: one en pulse every en_int cycles while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (en_on) begin
      en_cnt++;
      if (en_cnt >= en_int) begin
        en = 1'b1;
        en_cnt = 0;
      end else begin
        en = 1'b0;
      end
    end else begin
      en = 1'b0;
      en_cnt = 0;
    end
  end

  // Eager sources: offer the queue head whenever one exists, pop on an observed handshake.
  initial forever begin
    @(posedge clk);
    #1;
    if (v0 && rdy0 && !rst_smp) begin
      void'(src0.pop_front());
      pend0 = 1'b1;
    end
    if (v1 && rdy1 && !rst_smp) begin
      void'(src1.pop_front());
      pend1 = 1'b1;
    end
    s_valid = (src0.size() > 0);
    s_data  = (src0.size() > 0) ? src0[0] : 8'h00;
    c_valid = (src1.size() > 0);
    c_data  = (src1.size() > 0) ? src1[0] : 8'h00;
  end

  // Monitor: score every emitted bit against the expected streams.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (pend0) begin
      check("ready_drop0", s_ready, 1'b0);
      pend0 = 1'b0;
    end
    if (pend1) begin
      check("ready_drop1", c_ready, 1'b0);
      pend1 = 1'b0;
    end
    if (bit_valid) begin
      seen0++;
      if (first0 < 0) first0 = cyc;
      last0 = cyc;
      if (exp0.size() == 0) check("extra_bit0", bit_valid, 1'b0);
      else begin
        e = exp0.pop_front();
        check("bit0", bit_out, e.b);
        check("fs0", frame_start, e.fs);
        if (e.ws) check("ready_on_load0", s_ready, 1'b1);
      end
    end else if (frame_start) check("fs_alone0", frame_start, 1'b0);
    if (c_bv) begin
      seen1++;
      if (first1 < 0) first1 = cyc;
      last1 = cyc;
      if (exp1.size() == 0) check("extra_bit1", c_bv, 1'b0);
      else begin
        e = exp1.pop_front();
        check("bit1", c_bit, e.b);
        check("fs1", c_fs, e.fs);
      end
    end else if (c_fs) check("fs_alone1", c_fs, 1'b0);
    if (en && busy) busy_str0++;
    rdy0 = s_ready;
    rdy1 = c_ready;
    v0 = s_valid;
    v1 = c_valid;
    rst_smp = rst;
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    idle_cycles(1);
    while (i < budget && !(exp0.size() == 0 && exp1.size() == 0 && !busy && !c_busy)) begin
      idle_cycles(1);
      i++;
    end
    check("drain0", exp0.size(), 0);
    check("drain1", exp1.size(), 0);
    check("busy_end", {c_busy, busy}, 2'b00);
  endtask

  initial begin
    logic [7:0] wq[$];
    logic [7:0] grp[$];
    logic [31:0] pre13;
    int base;
    pre13 = {19'd0, BARKER13};

    // Reset state, sampled while rst is still asserted after a few edges.
    idle_cycles(3);
    check("rst_bit_out", bit_out, 1'b0);
    check("rst_bit_valid", bit_valid, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic frame at one bit per three cycles.
    wq = {8'hA5, 8'h3C, 8'hFF, 8'h00};
    foreach (wq[i]) src0.push_back(wq[i]);
    add_frame(0, wq, 4, 13, pre13, 2);
    idle_cycles(3);
    busy_str0 = 0;
    en_int = 3;
    en_on = 1'b1;
    wait_drain(1000);
    en_on = 1'b0;
    check("busy_strobes_basic", busy_str0, 47);
    check("no_underrun_basic", underrun, 1'b0);

    // Backpressure: three frames of random words at a random strobe rate.
    en_int = $urandom_range(1, 4);
    for (int f = 0; f < 3; f++) begin
      grp.delete();
      for (int i = 0; i < 4; i++) grp.push_back(8'($urandom));
      foreach (grp[i]) src0.push_back(grp[i]);
      add_frame(0, grp, 4, 13, pre13, 2);
    end
    idle_cycles(3);
    en_on = 1'b1;
    wait_drain(3000);
    en_on = 1'b0;
    check("no_underrun_bp", underrun, 1'b0);

    // Continuous en: one bit per clock, no holes.
    grp.delete();
    for (int i = 0; i < 4; i++) grp.push_back(8'($urandom));
    foreach (grp[i]) src0.push_back(grp[i]);
    add_frame(0, grp, 4, 13, pre13, 2);
    idle_cycles(3);
    first0 = -1;
    busy_str0 = 0;
    en_int = 1;
    en_on = 1'b1;
    wait_drain(500);
    en_on = 1'b0;
    check("contig_cont", last0 - first0 + 1, 47);
    check("busy_strobes_cont", busy_str0, 47);

    // Underrun: only two words for a four-word frame.
    grp.delete();
    for (int i = 0; i < 2; i++) grp.push_back(8'($urandom));
    foreach (grp[i]) src0.push_back(grp[i]);
    add_frame(0, grp, 4, 13, pre13, 2);
    idle_cycles(3);
    en_int = 2;
    en_on = 1'b1;
    wait_drain(500);
    check("underrun_set", underrun, 1'b1);
    base = seen0;
    idle_cycles(20);
    check("underrun_sticky", underrun, 1'b1);
    check("quiet_after_underrun", seen0 - base, 0);
    en_on = 1'b0;

    // Mid-frame reset at data bit 5 of word 1.
    grp.delete();
    for (int i = 0; i < 4; i++) grp.push_back(8'($urandom));
    foreach (grp[i]) src0.push_back(grp[i]);
    add_frame(0, grp, 4, 13, pre13, 2);
    idle_cycles(3);
    base = seen0;
    en_int = 2;
    en_on = 1'b1;
    for (int i = 0; i < 500 && seen0 < base + 19; i++) idle_cycles(1);
    check("reached_reset_point", seen0 - base, 19);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp0.delete();
    src0.delete();
    s_valid = 1'b0;
    base = seen0;
    @(negedge clk);
    #1;
    check("mrst_bit_valid", bit_valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_s_ready", s_ready, 1'b1);
    check("mrst_underrun", underrun, 1'b0);
    idle_cycles(30);
    check("quiet_after_rst", seen0 - base, 0);
    check("idle_after_rst", busy, 1'b0);
    en_on = 1'b0;
    grp.delete();
    for (int i = 0; i < 4; i++) grp.push_back(8'($urandom));
    foreach (grp[i]) src0.push_back(grp[i]);
    add_frame(0, grp, 4, 13, pre13, 2);
    idle_cycles(3);
    en_on = 1'b1;
    wait_drain(1000);
    en_on = 1'b0;

    // Parameter corner: 1-bit preamble, one word per frame, no gap, back-to-back frames.
    for (int f = 0; f < 5; f++) begin
      grp.delete();
      grp.push_back(8'($urandom));
      src1.push_back(grp[0]);
      add_frame(1, grp, 1, 1, 32'h1, 0);
    end
    idle_cycles(3);
    first1 = -1;
    base = seen1;
    en_int = 1;
    en_on = 1'b1;
    wait_drain(500);
    en_on = 1'b0;
    check("corner_bits", seen1 - base, 45);
    check("corner_contig", last1 - first1 + 1, 45);
    check("corner_underrun", c_under, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
